// File: rtl/juez_golpe.sv
// Rhythm-game hit judge: synchronizes and debounces five drum pads, detects strikes,
// and grades each falling note as hit or miss while keeping score and streak.
module juez_golpe #(
    parameter int ZONA_INI = 400,
    parameter int ZONA_FIN = 464,
    parameter int DEBOUNCE = 250000,
    parameter int PUNTOS   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [9:0]  posicionYS,
    input  logic [4:0]  carril,
    input  logic [4:0]  pads,
    output logic        acierto,
    output logic        fallo,
    output logic [15:0] puntaje,
    output logic [7:0]  racha,
    output logic [1:0]  estado
);

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        ZONA     = 2'd1,
        RESUELTO = 2'd2
    } estado_t;

    localparam logic [9:0]  L_INI    = 10'(ZONA_INI);
    localparam logic [9:0]  L_FIN    = 10'(ZONA_FIN);
    localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE - 1);
    localparam logic [16:0] P_BASE   = 17'(PUNTOS);
    localparam logic [16:0] P_BONO   = 17'(2 * PUNTOS);

    logic [4:0]  r_sync1;
    logic [4:0]  r_sync2;
    logic [4:0]  r_estable;
    logic [4:0]  r_establePrev;
    logic [4:0]  r_golpe;
    logic [19:0] r_cnt [5];

    estado_t     r_estado;
    estado_t     w_next;
    logic        w_hit;
    logic        w_miss;
    logic        w_enZona;
    logic        r_acierto;
    logic        r_fallo;
    logic [15:0] r_puntaje;
    logic [7:0]  r_racha;
    logic [16:0] w_incremento;
    logic [16:0] w_suma;

    // Two-flop synchronizer followed by a per-lane stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_estable <= '0;
            for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= pads;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] != r_estable[i]) begin
                    if (r_cnt[i] >= DEB_LAST) begin
                        r_estable[i] <= r_sync2[i];
                        r_cnt[i]     <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 20'd1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_establePrev <= '0;
            r_golpe       <= '0;
        end else begin
            r_establePrev <= r_estable;
            r_golpe       <= r_estable & ~r_establePrev;
        end
    end

    assign w_enZona = (posicionYS >= L_INI) && (posicionYS <= L_FIN);

    // A strike that lands as the note leaves the zone is still judged as a strike.
    always_comb begin
        w_next = r_estado;
        w_hit  = 1'b0;
        w_miss = 1'b0;
        if (enable) begin
            w_next = ESPERA;
        end else begin
            case (r_estado)
                ESPERA: begin
                    if (w_enZona) w_next = ZONA;
                end
                ZONA: begin
                    if ((carril != 5'd0) && (r_golpe != 5'd0)) begin
                        if (((r_golpe & carril) == carril) && ((r_golpe & ~carril) == 5'd0))
                            w_hit = 1'b1;
                        else
                            w_miss = 1'b1;
                        w_next = RESUELTO;
                    end else if ((r_golpe == 5'd0) && (posicionYS > L_FIN)) begin
                        w_miss = (carril != 5'd0);
                        w_next = RESUELTO;
                    end
                end
                RESUELTO: begin
                    if (posicionYS < L_INI) w_next = ESPERA;
                end
                default: w_next = ESPERA;
            endcase
        end
    end

    always_comb begin
        w_incremento = (r_racha < 8'd8) ? P_BASE : P_BONO;
        w_suma       = {1'b0, r_puntaje} + w_incremento;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado  <= ESPERA;
            r_acierto <= 1'b0;
            r_fallo   <= 1'b0;
            r_puntaje <= '0;
            r_racha   <= '0;
        end else begin
            r_estado  <= w_next;
            r_acierto <= w_hit;
            r_fallo   <= w_miss;
            if (w_hit) begin
                if (r_racha != 8'hFF) r_racha <= r_racha + 8'd1;
                r_puntaje <= w_suma[16] ? 16'hFFFF : w_suma[15:0];
            end else if (w_miss) begin
                r_racha <= '0;
            end
        end
    end

    assign acierto = r_acierto;
    assign fallo   = r_fallo;
    assign puntaje = r_puntaje;
    assign racha   = r_racha;
    assign estado  = r_estado;

endmodule

// File: tb/tb_juez_golpe.sv
// Directed bench for juez_golpe with a short debounce; a second instance with a
// large base score exercises score saturation.
module tb_juez_golpe;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  posicionYS;
    logic [4:0]  carril;
    logic [4:0]  pads;
    logic        acierto;
    logic        fallo;
    logic [15:0] puntaje;
    logic [7:0]  racha;
    logic [1:0]  estado;

    logic        hold2;
    logic        reset2;
    logic        acierto2;
    logic        fallo2;
    logic [15:0] puntaje2;
    logic [7:0]  racha2;
    logic [1:0]  estado2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign reset2 = reset | hold2;

    juez_golpe #(.ZONA_INI(400), .ZONA_FIN(464), .DEBOUNCE(4), .PUNTOS(10)) dut (
        .clk(clk), .reset(reset), .enable(enable), .posicionYS(posicionYS),
        .carril(carril), .pads(pads), .acierto(acierto), .fallo(fallo),
        .puntaje(puntaje), .racha(racha), .estado(estado)
    );

    juez_golpe #(.ZONA_INI(400), .ZONA_FIN(464), .DEBOUNCE(4), .PUNTOS(20000)) dutSat (
        .clk(clk), .reset(reset2), .enable(enable), .posicionYS(posicionYS),
        .carril(carril), .pads(pads), .acierto(acierto2), .fallo(fallo2),
        .puntaje(puntaje2), .racha(racha2), .estado(estado2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One falling note from Y=380 to 480, then wrap to 0; pads pressed at pressY, released 20 rows later.
    task automatic runNote(input logic [4:0] lanes, input logic [4:0] press, input int pressY,
                           output int hits, output int misses, output int hitY,
                           output int missY, output logic [1:0] estMid);
        hits = 0; misses = 0; hitY = -1; missY = -1; estMid = 2'd3;
        carril = lanes;
        for (int y = 380; y <= 480; y++) begin
            posicionYS = 10'(y);
            if (y == pressY) pads = press;
            if (y == pressY + 20) pads = 5'd0;
            tick();
            if (acierto) begin hits++; hitY = y; end
            if (fallo) begin misses++; missY = y; end
            if (y == 470) estMid = estado;
        end
        pads = 5'd0;
        posicionYS = 10'd0;
        repeat (3) begin
            tick();
            if (acierto) hits++;
            if (fallo) misses++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (estado !== 2'd0) begin errors++; $display("[TB] FAIL reset_estado: got %0d expected 0", estado); end
        checks++; if (acierto !== 1'b0) begin errors++; $display("[TB] FAIL reset_acierto: got %b expected 0", acierto); end
        checks++; if (fallo !== 1'b0) begin errors++; $display("[TB] FAIL reset_fallo: got %b expected 0", fallo); end
        checks++; if (puntaje !== 16'd0) begin errors++; $display("[TB] FAIL reset_puntaje: got %0d expected 0", puntaje); end
        checks++; if (racha !== 8'd0) begin errors++; $display("[TB] FAIL reset_racha: got %0d expected 0", racha); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clean_hit();
        int h, m, hy, my;
        logic [1:0] em;
        runNote(5'b00001, 5'b00001, 420, h, m, hy, my, em);
        checks++; if (h !== 1) begin errors++; $display("[TB] FAIL clean_hit_count: got %0d expected 1", h); end
        checks++; if (m !== 0) begin errors++; $display("[TB] FAIL clean_miss_count: got %0d expected 0", m); end
        checks++; if (hy - 420 + 1 !== 8) begin errors++; $display("[TB] FAIL clean_latency: got %0d expected 8", hy - 420 + 1); end
        checks++; if (puntaje !== 16'd10) begin errors++; $display("[TB] FAIL clean_puntaje: got %0d expected 10", puntaje); end
        checks++; if (racha !== 8'd1) begin errors++; $display("[TB] FAIL clean_racha: got %0d expected 1", racha); end
    endtask

    task automatic test_wrong_lane();
        int h, m, hy, my;
        logic [1:0] em;
        runNote(5'b00011, 5'b00001, 420, h, m, hy, my, em);
        checks++; if (m !== 1 || h !== 0) begin errors++; $display("[TB] FAIL partial_chord: got hits %0d misses %0d expected 0/1", h, m); end
        checks++; if (racha !== 8'd0) begin errors++; $display("[TB] FAIL partial_racha: got %0d expected 0", racha); end
        checks++; if (puntaje !== 16'd10) begin errors++; $display("[TB] FAIL partial_puntaje: got %0d expected 10", puntaje); end
    endtask

    task automatic test_chord();
        int h, m, hy, my;
        logic [1:0] em;
        runNote(5'b00011, 5'b00011, 420, h, m, hy, my, em);
        checks++; if (h !== 1 || m !== 0) begin errors++; $display("[TB] FAIL chord_hit: got hits %0d misses %0d expected 1/0", h, m); end
        checks++; if (puntaje !== 16'd20) begin errors++; $display("[TB] FAIL chord_puntaje: got %0d expected 20", puntaje); end
        checks++; if (racha !== 8'd1) begin errors++; $display("[TB] FAIL chord_racha: got %0d expected 1", racha); end
    endtask

    task automatic test_missed();
        int h, m, hy, my;
        logic [1:0] em;
        runNote(5'b00001, 5'b00000, -100, h, m, hy, my, em);
        checks++; if (m !== 1 || h !== 0) begin errors++; $display("[TB] FAIL missed_count: got hits %0d misses %0d expected 0/1", h, m); end
        checks++; if (my !== 465) begin errors++; $display("[TB] FAIL missed_row: got %0d expected 465", my); end
        checks++; if (em !== 2'd2) begin errors++; $display("[TB] FAIL missed_resuelto: got %0d expected 2", em); end
        checks++; if (estado !== 2'd0) begin errors++; $display("[TB] FAIL missed_wrap: got %0d expected 0", estado); end
        checks++; if (racha !== 8'd0 || puntaje !== 16'd20) begin errors++; $display("[TB] FAIL missed_score: got %0d/%0d expected 20/0", puntaje, racha); end
    endtask

    task automatic test_zone_edges();
        int h, m, hy, my;
        logic [1:0] em;
        runNote(5'b00001, 5'b00001, 458, h, m, hy, my, em);
        checks++; if (h !== 1 || m !== 0) begin errors++; $display("[TB] FAIL exit_priority: got hits %0d misses %0d expected 1/0", h, m); end
        runNote(5'b00001, 5'b00001, 393, h, m, hy, my, em);
        checks++; if (h !== 0 || m !== 1 || my !== 465) begin errors++; $display("[TB] FAIL early_ignored: got hits %0d misses %0d row %0d expected 0/1/465", h, m, my); end
        runNote(5'b00001, 5'b00001, 394, h, m, hy, my, em);
        checks++; if (h !== 1 || m !== 0) begin errors++; $display("[TB] FAIL first_zone_row: got hits %0d misses %0d expected 1/0", h, m); end
    endtask

    task automatic test_bonus();
        int h, m, hy, my, total;
        logic [1:0] em;
        total = 0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        hold2 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            runNote(5'b00100, 5'b00100, 420, h, m, hy, my, em);
            total += h;
            if (i == 2) begin
                checks++; if (puntaje2 !== 16'd60000) begin errors++; $display("[TB] FAIL sat_pre: got %0d expected 60000", puntaje2); end
            end
        end
        checks++; if (total !== 9) begin errors++; $display("[TB] FAIL bonus_hits: got %0d expected 9", total); end
        checks++; if (puntaje !== 16'd100) begin errors++; $display("[TB] FAIL bonus_puntaje: got %0d expected 100", puntaje); end
        checks++; if (racha !== 8'd9) begin errors++; $display("[TB] FAIL bonus_racha: got %0d expected 9", racha); end
        checks++; if (puntaje2 !== 16'd65535) begin errors++; $display("[TB] FAIL sat_puntaje: got %0d expected 65535", puntaje2); end
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        carril = 5'b00001;
        posicionYS = 10'd420;
        repeat (2) tick();
        checks++; if (estado !== 2'd1) begin errors++; $display("[TB] FAIL glitch_zona: got %0d expected 1", estado); end
        pads = 5'b00001;
        repeat (3) tick();
        pads = 5'b00000;
        repeat (15) begin
            tick();
            if (acierto || fallo) pulses++;
        end
        checks++; if (pulses !== 0 || estado !== 2'd1) begin errors++; $display("[TB] FAIL glitch_pulse: got pulses %0d estado %0d expected 0/1", pulses, estado); end
    endtask

    task automatic test_enable();
        int pulses;
        pulses = 0;
        enable = 1'b1;
        tick();
        checks++; if (estado !== 2'd0) begin errors++; $display("[TB] FAIL enable_estado: got %0d expected 0", estado); end
        checks++; if (puntaje !== 16'd100 || racha !== 8'd9) begin errors++; $display("[TB] FAIL enable_kept: got %0d/%0d expected 100/9", puntaje, racha); end
        enable = 1'b0;
        tick();
        checks++; if (estado !== 2'd1) begin errors++; $display("[TB] FAIL enable_rearm: got %0d expected 1", estado); end
        enable = 1'b1;
        pads = 5'b00001;
        repeat (12) begin
            tick();
            if (acierto || fallo) pulses++;
        end
        enable = 1'b0;
        pads = 5'b00000;
        repeat (12) begin
            tick();
            if (acierto || fallo) pulses++;
        end
        checks++; if (pulses !== 0 || puntaje !== 16'd100) begin errors++; $display("[TB] FAIL enable_priority: got pulses %0d puntaje %0d expected 0/100", pulses, puntaje); end
    endtask

    task automatic test_reset_pending();
        int pulses;
        pulses = 0;
        pads = 5'b00001;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        pads = 5'b00000;
        tick();
        checks++; if (estado !== 2'd0 || acierto !== 1'b0 || fallo !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_outputs: got estado %0d acierto %b fallo %b expected 0/0/0", estado, acierto, fallo); end
        checks++; if (puntaje !== 16'd0 || racha !== 8'd0) begin errors++; $display("[TB] FAIL rst_mid_score: got %0d/%0d expected 0/0", puntaje, racha); end
        reset = 1'b0;
        repeat (20) begin
            tick();
            if (acierto || fallo) pulses++;
        end
        checks++; if (pulses !== 0 || estado !== 2'd1) begin errors++; $display("[TB] FAIL rst_mid_after: got pulses %0d estado %0d expected 0/1", pulses, estado); end
    endtask

    initial begin
        reset = 1'b1;
        hold2 = 1'b1;
        enable = 1'b0;
        posicionYS = 10'd0;
        carril = 5'd0;
        pads = 5'd0;
        test_reset();
        test_clean_hit();
        test_wrong_lane();
        test_chord();
        test_missed();
        test_zone_edges();
        test_bonus();
        test_glitch();
        test_enable();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/juez_golpe.md
JUEZ_GOLPE -- requirements
Module: juez_golpe

Interface
REQ-001 SHALL have parameter ZONA_INI, default 400, meaning the first note-top Y row (inclusive) of the hit zone.
REQ-002 SHALL have parameter ZONA_FIN, default 464, meaning the last note-top Y row (inclusive) of the hit zone.
REQ-003 SHALL have parameter DEBOUNCE, default 250000, meaning the number of consecutive stable cycles a pad must hold before a change is accepted (20-bit counter).
REQ-004 SHALL have parameter PUNTOS, default 10, meaning the base score per hit.
REQ-005 SHALL use one clock and a synchronous, active-high reset, named as follows:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  re-arms the per-note judgement.
- posicionYS  in  10  current top row of the falling note.
- carril  in  5  lanes the current note occupies; 0 means no note.
- pads  in  5  raw drum pads, active-high, asynchronous to clk.
- acierto  out  1  one-cycle hit pulse.
- fallo  out  1  one-cycle miss pulse.
- puntaje  out  16  accumulated score.
- racha  out  8  consecutive-hit count.
- estado  out  2  FSM state for debug: 0=ESPERA, 1=ZONA, 2=RESUELTO.

Function
REQ-006 Each pad bit SHALL pass through a 2-flop synchronizer and then its own debouncer.
REQ-007 Debouncer SHALL update its stable value only after the synchronized input has differed from it for DEBOUNCE consecutive cycles; any glitch SHALL restart the count.
REQ-008 golpe[i] SHALL be a one-cycle pulse on each 0->1 transition of stable pad i; releases produce no pulse.
REQ-009 Latency from a clean pad rise to acierto/fallo SHALL be exactly DEBOUNCE+4 cycles:
- 2 cycles synchronizer.
- DEBOUNCE cycles debounce.
- 1 cycle edge detect.
- 1 cycle registered judgement.
REQ-010 enZona SHALL be true when ZONA_INI <= posicionYS <= ZONA_FIN, using unsigned 10-bit compare.
REQ-011 In ESPERA: go to ZONA when enZona; ignore golpe (no pulse, no penalty).
REQ-012 In ZONA, with carril != 0 and golpe != 0, judge exactly once:
- Hit when (golpe & carril) == carril and (golpe & ~carril) == 0: pulse acierto, go to RESUELTO.
- Otherwise: pulse fallo, go to RESUELTO.
REQ-013 In ZONA with golpe == 0 and posicionYS > ZONA_FIN: pulse fallo if carril != 0, no pulse if carril == 0; go to RESUELTO either way.
REQ-014 If golpe arrives in the same cycle the note leaves the zone, REQ-012 SHALL take priority over REQ-013.
REQ-015 In RESUELTO: ignore golpe; go to ESPERA when posicionYS < ZONA_INI (note wrap).
REQ-016 Chords (multi-bit golpe) SHALL count as a hit only if every carril bit is present in the same cycle; partial strikes SHALL count as fallo.
REQ-017 On acierto, racha SHALL increment, saturating at 255.
REQ-018 On acierto, puntaje SHALL add PUNTOS if the pre-increment racha < 8, else 2*PUNTOS, saturating at 65535.
REQ-019 On fallo, racha SHALL clear to 0 and puntaje SHALL be unchanged.
REQ-020 acierto and fallo SHALL never assert in the same cycle, and each SHALL assert for at most one cycle per note.
REQ-021 enable=1 SHALL force the FSM to ESPERA next cycle with no pulse; puntaje and racha SHALL be kept; enable SHALL take priority over any judgement in that cycle.

Reset
REQ-022 reset SHALL take priority over enable and all other inputs.
REQ-023 On reset, estado=ESPERA, acierto=0, fallo=0, puntaje=0, racha=0, and all synchronizer, debouncer and edge flops SHALL clear to 0.
REQ-024 Reset asserted mid-debounce or in ZONA SHALL discard the pending press, with no pulse after release.
REQ-025 A pad held high through reset release SHALL produce golpe only after DEBOUNCE stable cycles from release.

Verification (DEBOUNCE=4, ZONA_INI=400, ZONA_FIN=464, PUNTOS=10)
REQ-026 Clean hit: carril=00001, posicionYS ramps 0..480, pads=00001 rises at Y=420 -> acierto one cycle, 8 cycles after the rise; puntaje=10, racha=1.
REQ-027 Wrong lane and chord:
- carril=00011 with pads=00001 in zone -> fallo, racha=0.
- Next note with pads=00011 rising together -> acierto.
REQ-028 Missed note: no press, posicionYS passes 465 -> fallo in the cycle after Y=465, then RESUELTO until wrap to 0, then ESPERA.
REQ-029 Bonus and saturation:
- 9 consecutive hits -> puntaje=100 (8x10 + 1x20), racha=9.
- Preloaded near 65535 -> puntaje stays at 65535.
REQ-030 Glitch/reset:
- 3-cycle pad pulse -> no golpe.
- reset during ZONA with a press pending -> all outputs 0, no pulse afterwards.
- enable during ZONA -> estado=0 next cycle, score kept.
